fetch_queue: RTL and testbench

//  Parametrised successor to the single-PC fetch stage. Generates sequential fetch

---
 rtl/tinker_pkg.sv | 19 +
 rtl/fetch_queue_chk.sv | 28 ++
 rtl/fetch_queue_fifo.sv | 82 ++++++++
 rtl/fetch_queue.sv | 135 +++++++++++++
 tb/tb_fetch_queue.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/tinker_pkg.sv
// Shared fetch-path definitions: widths, reset PC and the queued instruction record.
package tinker_pkg;

   localparam int ADDR_W = 64;
   localparam int INSTR_W = 32;
   localparam logic [ADDR_W-1:0] RESET_PC = 64'h2000;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

   // Clear the sub-instruction offset bits of a redirect target.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
      return pc & ~ADDR_W'(INSTR_BYTES - 1);
   endfunction

endpackage

// File: rtl/fetch_queue_chk.sv
// Protocol and bookkeeping assertions for fetch_queue.
module fetch_queue_chk #(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input logic             clk,
   input logic             reset,
   input logic             resp_valid,
   input logic [CNT_W-1:0] inflight,
   input logic [CNT_W-1:0] drop,
   input logic [CNT_W-1:0] inst_count,
   input logic [CNT_W-1:0] tag_count
);

   a_resp_needs_request: assert property (@(posedge clk) disable iff (!reset)
      resp_valid |-> (inflight != {CNT_W{1'b0}}));

   a_drop_bounded: assert property (@(posedge clk) disable iff (!reset)
      drop <= inflight);

   a_occupancy_bounded: assert property (@(posedge clk) disable iff (!reset)
      ({1'b0, inst_count} + {1'b0, inflight}) <= (CNT_W + 1)'(DEPTH));

   // Every live (non-dropped) request owns exactly one PC tag.
   a_tags_track_live: assert property (@(posedge clk) disable iff (!reset)
      tag_count == (inflight - drop));

endmodule

// File: rtl/fetch_queue_fifo.sv
// Synchronous DEPTH-entry FIFO with a flush input; the head is readable without a pop.
module fetch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count
);

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign do_push_s = push && !flush && (count_q != CNT_FULL);
   assign do_pop_s  = pop && !flush && (count_q != {CNT_W{1'b0}});
   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

   // Pointer, occupancy and storage next-state; flush wins over push/pop.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; storage is cleared so the head reads zero out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Sequential fetch-address generator with an in-order instruction queue and redirect flush.
module fetch_queue
   import tinker_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               req_valid,
   input  logic               req_ready,
   output logic [ADDR_W-1:0]  req_addr,
   input  logic               resp_valid,
   input  logic [INSTR_W-1:0] resp_data,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic [INSTR_W-1:0] inst_data,
   output logic [ADDR_W-1:0]  inst_pc
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [CNT_W-1:0]  inst_count_s;
   logic [CNT_W-1:0]  tag_count_s;
   logic [CNT_W:0]    occupancy_s;
   logic [ADDR_W-1:0] tag_head_s;
   fetch_entry_t      inst_head_s;
   fetch_entry_t      inst_push_s;
   logic              req_fire_s;
   logic              resp_ok_s;
   logic              keep_s;
   logic              deq_s;

   // Queued entries plus outstanding requests never exceed the queue depth.
   assign occupancy_s = {1'b0, inst_count_s} + {1'b0, inflight_q};
   assign req_valid   = reset && !redirect && (occupancy_s < (CNT_W + 1)'(DEPTH));
   assign req_addr    = fetch_pc_q;
   assign req_fire_s  = req_valid && req_ready;
   assign resp_ok_s   = resp_valid && (inflight_q != CNT_ZERO);
   assign keep_s      = resp_ok_s && (drop_q == CNT_ZERO) && !redirect;
   assign deq_s       = inst_valid && inst_ready && !redirect;
   assign inst_push_s = {resp_data, tag_head_s};
   assign inst_valid  = (inst_count_s != CNT_ZERO);
   assign inst_data   = inst_head_s.instr;
   assign inst_pc     = inst_head_s.pc;

   // Fetch PC and in-flight/drop bookkeeping; a redirect overrides every other event.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      if (redirect) begin
         fetch_pc_d = align_pc(redirect_pc);
         inflight_d = resp_ok_s ? (inflight_q - CNT_ONE) : inflight_q;
         drop_d     = inflight_d;
      end else begin
         if (req_fire_s) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         case ({req_fire_s, resp_ok_s})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01:   inflight_d = inflight_q - CNT_ONE;
            default: inflight_d = inflight_q;
         endcase
         if (resp_ok_s && (drop_q != CNT_ZERO)) begin
            drop_d = drop_q - CNT_ONE;
         end else begin
            drop_d = drop_q;
         end
      end
   end

   // Fetch state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= CNT_ZERO;
         drop_q     <= CNT_ZERO;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(
      .WIDTH($bits(fetch_entry_t)),
      .DEPTH(DEPTH)
   ) u_inst_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (redirect),
      .push     (keep_s),
      .push_data(inst_push_s),
      .pop      (deq_s),
      .head_data(inst_head_s),
      .count    (inst_count_s)
   );

   // PC tags pair each response with its request address; stale responses never pop.
   fetch_fifo #(
      .WIDTH(ADDR_W),
      .DEPTH(DEPTH)
   ) u_tag_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (redirect),
      .push     (req_fire_s),
      .push_data(fetch_pc_q),
      .pop      (keep_s),
      .head_data(tag_head_s),
      .count    (tag_count_s)
   );

   fetch_queue_chk #(
      .DEPTH(DEPTH)
   ) u_chk (
      .clk       (clk),
      .reset     (reset),
      .resp_valid(resp_valid),
      .inflight  (inflight_q),
      .drop      (drop_q),
      .inst_count(inst_count_s),
      .tag_count (tag_count_s)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner sequences, random run vs queue model.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [63:0] inst_pc;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst_data  (inst_data),
      .inst_pc    (inst_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: queued instructions and outstanding requests (stale ones get discarded).
   typedef struct { logic [63:0] addr; int due; bit stale; } pend_t;
   typedef struct { logic [31:0] instr; logic [63:0] pc; } ent_t;
   pend_t       pend[$];
   ent_t        mq[$];
   logic [63:0] m_pc;
   int          cyc;

   typedef struct {
      bit rr; bit rv; logic [31:0] rd; bit ir;
      bit erv; logic [63:0] eaddr; bit eiv; logic [63:0] epc; logic [31:0] edata;
   } vec_t;
   vec_t tbl [13];

   function automatic logic [31:0] mem_data(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic expired(input string name);
      n_chk++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   task automatic do_reset();
      reset = 1'b0; redirect = 1'b0; redirect_pc = 64'h0; req_ready = 1'b0;
      resp_valid = 1'b0; resp_data = 32'h0; inst_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_req_valid", req_valid, 1'b0);
      chk("rst_req_addr", req_addr, 64'h2000);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_inst_pc", inst_pc, 64'h0);
      reset = 1'b1;
      pend.delete(); mq.delete(); m_pc = 64'h2000; cyc = 0;
   endtask

   // One clock cycle: memory responds from the outstanding list, outputs checked against the model.
   task automatic step(input bit rr, input bit ir, input bit redir, input logic [63:0] rpc, input int lat);
      bit    rv, exp_rv, have_new;
      pend_t p;
      ent_t  e;
      rv = (pend.size() > 0) && (pend[0].due <= cyc);
      req_ready = rr; inst_ready = ir; redirect = redir; redirect_pc = rpc;
      resp_valid = rv; resp_data = rv ? mem_data(pend[0].addr) : 32'h0;
      #4;
      exp_rv = !redir && ((mq.size() + pend.size()) < DEPTH);
      chk("req_valid", req_valid, exp_rv);
      chk("req_addr", req_addr, m_pc);
      chk("inst_valid", inst_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("inst_pc", inst_pc, mq[0].pc);
         chk("inst_data", inst_data, mq[0].instr);
      end
      have_new = 1'b0;
      if (rv) begin
         p = pend.pop_front();
         if (!redir && !p.stale) begin
            e.instr = mem_data(p.addr); e.pc = p.addr; have_new = 1'b1;
         end
      end
      if (!redir && ir && mq.size() > 0) void'(mq.pop_front());
      if (have_new) mq.push_back(e);
      if (exp_rv && rr) begin
         pend.push_back('{m_pc, cyc + lat, 1'b0});
         m_pc = m_pc + 64'd4;
      end
      if (redir) begin
         mq.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         m_pc = rpc & ~64'd3;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      int seen;
      tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 64'h2000, 1'b0, 64'h0,    32'h0};
      tbl[1]  = '{1'b1, 1'b1, 32'hA0, 1'b0, 1'b1, 64'h2004, 1'b0, 64'h0,    32'h0};
      tbl[2]  = '{1'b1, 1'b1, 32'hA1, 1'b0, 1'b1, 64'h2008, 1'b1, 64'h2000, 32'hA0};
      tbl[3]  = '{1'b1, 1'b1, 32'hA2, 1'b0, 1'b1, 64'h200C, 1'b1, 64'h2000, 32'hA0};
      tbl[4]  = '{1'b1, 1'b1, 32'hA3, 1'b0, 1'b0, 64'h2010, 1'b1, 64'h2000, 32'hA0};
      tbl[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 64'h2010, 1'b1, 64'h2000, 32'hA0};
      tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 64'h2010, 1'b1, 64'h2000, 32'hA0};
      tbl[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 64'h2010, 1'b1, 64'h2004, 32'hA1};
      tbl[8]  = '{1'b1, 1'b1, 32'hA4, 1'b1, 1'b1, 64'h2014, 1'b1, 64'h2008, 32'hA2};
      tbl[9]  = '{1'b0, 1'b1, 32'hA5, 1'b1, 1'b1, 64'h2018, 1'b1, 64'h200C, 32'hA3};
      tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 64'h2018, 1'b1, 64'h2010, 32'hA4};
      tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 64'h2018, 1'b1, 64'h2014, 32'hA5};
      tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 64'h2018, 1'b0, 64'h0,    32'h0};

      // Fill to full with decode stalled, then drain in order.
      do_reset();
      for (int i = 0; i < 13; i++) begin
         req_ready = tbl[i].rr; resp_valid = tbl[i].rv; resp_data = tbl[i].rd;
         inst_ready = tbl[i].ir; redirect = 1'b0;
         #4;
         chk($sformatf("tbl%0d_req_valid", i), req_valid, tbl[i].erv);
         chk($sformatf("tbl%0d_req_addr", i), req_addr, tbl[i].eaddr);
         chk($sformatf("tbl%0d_inst_valid", i), inst_valid, tbl[i].eiv);
         if (tbl[i].eiv) begin
            chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].epc);
            chk($sformatf("tbl%0d_inst_data", i), inst_data, tbl[i].edata);
         end
         @(posedge clk); #1;
      end

      // 1-cycle memory streams one instruction per cycle.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 64'h0, 1);
      step(1'b1, 1'b1, 1'b0, 64'h0, 1);
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         if (inst_valid) seen++;
         step(1'b1, 1'b1, 1'b0, 64'h0, 1);
      end
      chk("t1_throughput", seen, 20);

      // Redirect with three requests in flight on 3-cycle memory.
      do_reset();
      for (int k = 0; k < 10 && pend.size() != 3; k++) step(1'b1, 1'b1, 1'b0, 64'h0, 3);
      if (pend.size() != 3) expired("t3_setup");
      step(1'b1, 1'b1, 1'b1, 64'h3001, 3);
      chk("t3_redirect_addr", req_addr, 64'h3000);
      for (int k = 0; k < 20 && !inst_valid; k++) step(1'b1, 1'b1, 1'b0, 64'h0, 3);
      if (!inst_valid) expired("t3_first_inst");
      chk("t3_first_pc", inst_pc, 64'h3000);

      // Redirect coinciding with a response and a dequeue handshake.
      do_reset();
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 64'h0, 1);
      step(1'b1, 1'b1, 1'b1, 64'h4000, 1);
      chk("t4_inst_valid_after", inst_valid, 1'b0);

      // Redirect to the top of the address space wraps to zero.
      step(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
      chk("t5_top_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      step(1'b1, 1'b1, 1'b0, 64'h0, 1);
      chk("t5_wrap_addr", req_addr, 64'h0);

      // Asynchronous reset mid-stream with two queued and two in flight.
      do_reset();
      for (int k = 0; k < 20 && !(mq.size() == 2 && pend.size() == 2); k++)
         step(1'b1, 1'b0, 1'b0, 64'h0, 2);
      if (!(mq.size() == 2 && pend.size() == 2)) expired("t6_setup");
      #2; reset = 1'b0; #1;
      chk("t6_async_req_valid", req_valid, 1'b0);
      chk("t6_async_inst_valid", inst_valid, 1'b0);
      chk("t6_async_inst_data", inst_data, 32'h0);
      chk("t6_async_inst_pc", inst_pc, 64'h0);
      chk("t6_async_req_addr", req_addr, 64'h2000);
      do_reset();
      chk("t6_refetch_addr", req_addr, 64'h2000);
      for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 64'h0, 1);

      // Random traffic against the model.
      do_reset();
      for (int k = 0; k < 1500; k++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              {$urandom, $urandom}, $urandom_range(1, 4));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
